// File: rtl/bp_be_fe_queue_buffer_pkg.sv
// Shared FE-queue definitions: default packet width and depth, plus the packet type.
package bp_be_fe_queue_buffer_pkg;

  localparam int fe_queue_width_gp = 128;
  localparam int fe_queue_els_gp   = 8;

  typedef logic [fe_queue_width_gp-1:0] fe_queue_pkt_t;

endpackage

// File: rtl/bp_be_fe_queue_ptr.sv
// Wrapping pointer register with increment enable and synchronous load.
// Load takes priority over increment.
module bp_be_fe_queue_ptr #(
  parameter int width_p = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               incr_i,
  input  logic               load_i,
  input  logic [width_p-1:0] load_val_i,
  output logic [width_p-1:0] ptr_o
);

  logic [width_p-1:0] ptr_d, ptr_q;

  // NOTE: give every always_comb output a default first so no path leaves it unassigned (no latch).
  always_comb begin
    ptr_d = ptr_q;
    if (load_i) begin
      ptr_d = load_val_i;
    end else if (incr_i) begin
      ptr_d = ptr_q + width_p'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/bp_be_fe_queue_buffer.sv
// Speculative FE-queue FIFO: write, read (speculative) and commit pointers over one storage array.
// Optional 0-cycle bypass of an incoming packet when no stored entry is unread: BP_FE_QUEUE_BYPASS_EN.
module bp_be_fe_queue_buffer
  import bp_be_fe_queue_buffer_pkg::*;
#(
  parameter int els_p   = fe_queue_els_gp,
  parameter int width_p = fe_queue_width_gp
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               clr_i,
  input  logic [width_p-1:0] fe_queue_i,
  input  logic               fe_queue_v_i,
  output logic               fe_queue_ready_o,
  output logic [width_p-1:0] fe_queue_o,
  output logic               fe_queue_v_o,
  input  logic               fe_queue_yumi_i,
  input  logic               commit_v_i,
  input  logic               roll_v_i,
  output logic               empty_o,
  output logic               full_o
);

  localparam int ptr_width_lp = $clog2(els_p) + 1;
  localparam int idx_width_lp = ptr_width_lp - 1;
  // Pointers one lap apart differ only in the wrap bit.
  localparam logic [ptr_width_lp-1:0] full_xor_lp = {1'b1, {idx_width_lp{1'b0}}};

  logic [ptr_width_lp-1:0] wptr, rptr, cptr;
  logic [ptr_width_lp-1:0] cptr_next, rptr_load_val;
  logic                    enq, deq, com, roll, rptr_load, stored_v;
  logic [width_p-1:0]      mem_q [els_p];

  always_comb begin
    full_o           = (wptr ^ cptr) == full_xor_lp;
    empty_o          = wptr == cptr;
    fe_queue_ready_o = ~full_o;
    stored_v         = rptr != wptr;
    fe_queue_v_o     = stored_v;
    fe_queue_o       = mem_q[rptr[idx_width_lp-1:0]];
`ifdef BP_FE_QUEUE_BYPASS_EN
    // Bypass is gated by ready so a taken bypass packet is always also written.
    if (!stored_v && !clr_i && !roll_v_i) begin
      fe_queue_v_o = fe_queue_v_i & fe_queue_ready_o;
      fe_queue_o   = fe_queue_i;
    end
`endif
    enq           = fe_queue_v_i & fe_queue_ready_o & ~clr_i;
    deq           = fe_queue_yumi_i & ~roll_v_i & ~clr_i;
    com           = commit_v_i & ~clr_i;
    roll          = roll_v_i & ~clr_i;
    cptr_next     = cptr + {{idx_width_lp{1'b0}}, com};
    rptr_load     = clr_i | roll;
    rptr_load_val = clr_i ? '0 : cptr_next;
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      mem_q[wptr[idx_width_lp-1:0]] <= fe_queue_i;
    end
  end

  bp_be_fe_queue_ptr #(.width_p(ptr_width_lp)) u_wptr (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .incr_i     (enq),
    .load_i     (clr_i),
    .load_val_i ({ptr_width_lp{1'b0}}),
    .ptr_o      (wptr)
  );

  bp_be_fe_queue_ptr #(.width_p(ptr_width_lp)) u_rptr (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .incr_i     (deq),
    .load_i     (rptr_load),
    .load_val_i (rptr_load_val),
    .ptr_o      (rptr)
  );

  bp_be_fe_queue_ptr #(.width_p(ptr_width_lp)) u_cptr (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .incr_i     (com),
    .load_i     (clr_i),
    .load_val_i ({ptr_width_lp{1'b0}}),
    .ptr_o      (cptr)
  );

  a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (fe_queue_yumi_i && !clr_i && !roll_v_i) |-> fe_queue_v_o);

  a_commit_needs_dequeued: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (commit_v_i && !clr_i) |-> (cptr != rptr));

endmodule
